// File: rtl/psconverter.sv
// Purpose : parallel-to-serial converter with a one-word holding buffer for back-to-back words.
// Latency : the first bit of a word accepted at edge N is on sout in the cycle after edge N.
// Backpr. : pin_ready drops while the holding register is full, so at most two words are in flight.
//
// Ports:
//   clk         - single clock, all state changes on its rising edge
//   rst         - asynchronous active-low reset
//   pin         - parallel word from the producer (WIDTH bits)
//   pin_valid   - pin holds a word to transfer
//   pin_ready   - a word can be accepted this cycle
//   sout        - serial data bit (MSB or LSB first, selected by MSB_FIRST)
//   sout_valid  - sout carries a valid bit this cycle
//   sout_last   - sout carries the final bit of a word
//   busy        - a word is being shifted or a word is buffered
module psconverter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             pin_valid,
    output logic             pin_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg_shifted;
    logic             xfer;
    logic             at_last;

    // A transfer can only happen when not in reset and the hold slot is free.
    assign xfer    = pin_valid & pin_ready;
    assign at_last = (state == SHIFT) && (cnt == CNT_LAST);

    // Move the register one position toward the output end, zero-filling behind.
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: SHIFT persists across a word boundary whenever another
    // word is ready (buffered or arriving in the last-bit cycle), which is
    // what keeps consecutive words gap-free.
    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (xfer) begin
                state_nxt = SHIFT;
            end
        end else begin
            if (at_last && !hold_full && !xfer) begin
                state_nxt = IDLE;
            end
        end
    end

    // Output logic. sout is gated by SHIFT so stale shift-register contents
    // never leak onto the serial line while idle.
    always_comb begin
        sout_valid = (state == SHIFT);
        sout_last  = at_last;
        sout       = sout_valid & ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
        busy       = sout_valid | hold_full;
        pin_ready  = rst & ~hold_full;
    end

    // Datapath: shift register, holding register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            if (state == IDLE) begin
                if (xfer) begin
                    shreg <= pin;
                    cnt   <= '0;
                end
            end else if (!at_last) begin
                shreg <= shreg_shifted;
                cnt   <= cnt + CW'(1);
                // A word arriving mid-shift waits in the holding register.
                if (xfer) begin
                    hold      <= pin;
                    hold_full <= 1'b1;
                end
            end else if (hold_full) begin
                // Buffered word takes priority; pin_ready is low so no
                // transfer can coincide with this reload.
                shreg     <= hold;
                hold_full <= 1'b0;
                cnt       <= '0;
            end else if (xfer) begin
                // Word arriving in the last-bit cycle bypasses the holding register.
                shreg <= pin;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psconverter.sv
module tb_psconverter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pin;
    logic       pin_valid;
    logic       pin_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_last;
    logic       busy;

    logic [3:0] pin4;
    logic       pin4_valid;
    logic       pin4_ready;
    logic       sout4;
    logic       sout4_valid;
    logic       sout4_last;
    logic       busy4;

    logic [4:0] obs;
    logic [4:0] obs4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    psconverter #(.WIDTH(8), .MSB_FIRST(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pin        (pin),
        .pin_valid  (pin_valid),
        .pin_ready  (pin_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    psconverter #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .pin        (pin4),
        .pin_valid  (pin4_valid),
        .pin_ready  (pin4_ready),
        .sout       (sout4),
        .sout_valid (sout4_valid),
        .sout_last  (sout4_last),
        .busy       (busy4)
    );

    // Observed output vector: {sout_valid, sout_last, sout, busy, pin_ready}
    assign obs  = {sout_valid, sout_last, sout, busy, pin_ready};
    assign obs4 = {sout4_valid, sout4_last, sout4, busy4, pin4_ready};

    task automatic test_reset;
        rst        = 1'b0;
        pin        = 8'h00;
        pin_valid  = 1'b0;
        pin4       = 4'h0;
        pin4_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_hold: vld/last/sout/busy/rdy got %b want %b", obs, 5'b00000);
        end
        n_checks++;
        if (obs4 !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_hold_lsb: vld/last/sout/busy/rdy got %b want %b", obs4, 5'b00000);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_release: vld/last/sout/busy/rdy got %b want %b", obs, 5'b00001);
        end
        n_checks++;
        if (obs4 !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_release_lsb: vld/last/sout/busy/rdy got %b want %b", obs4, 5'b00001);
        end
        @(negedge clk);
    endtask

    // 0xA5 MSB-first: 1,0,1,0,0,1,0,1 in cycles 1..8, idle in cycle 9.
    task automatic test_single_word;
        logic [7:0] stream = 8'b1010_0101;
        logic [4:0] exp;
        pin       = 8'hA5;
        pin_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                pin_valid = 1'b0;
                pin       = 8'hFF;  // noise without valid must be ignored
            end
            if (c <= 8) exp = {1'b1, (c == 8), stream[8-c], 1'b1, 1'b1};
            else        exp = 5'b00001;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_word cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs, exp);
            end
        end
    endtask

    // 0xA5 at edge 0, 0x3C at edge 1 into the hold slot: 16 contiguous bits.
    task automatic test_back_to_back;
        logic [15:0] stream = 16'b1010_0101_0011_1100;
        logic [4:0]  exp;
        logic        rdy;
        pin       = 8'hA5;
        pin_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) pin = 8'h3C;
            if (c == 2) begin
                pin_valid = 1'b0;
                pin       = 8'h00;
            end
            rdy = !(c >= 2 && c <= 8);
            if (c <= 16) exp = {1'b1, (c == 8 || c == 16), stream[16-c], 1'b1, rdy};
            else         exp = 5'b00001;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs, exp);
            end
        end
    endtask

    // pin_valid held high across three words; producer advances only on a transfer.
    task automatic test_backpressure;
        logic [7:0]  words [3];
        logic [23:0] stream = 24'b1000_0001_0100_0010_1001_1001;
        logic [4:0]  exp;
        logic        rdy;
        logic        xf;
        int          k = 0;
        words[0]  = 8'h81;
        words[1]  = 8'h42;
        words[2]  = 8'h99;
        pin       = words[0];
        pin_valid = 1'b1;
        xf        = pin_valid && pin_ready;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (xf) begin
                k++;
                if (k < 3) pin = words[k];
                else       pin_valid = 1'b0;
            end
            rdy = (c == 1) || (c == 9) || (c >= 17);
            if (c <= 24) exp = {1'b1, (c % 8 == 0), stream[24-c], 1'b1, rdy};
            else         exp = 5'b00001;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs, exp);
            end
            xf = pin_valid && pin_ready;
        end
        n_checks++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL backpressure_accepts: words accepted got %0d want %0d", k, 3);
        end
    endtask

    // 0xFF shifting plus a second 0xFF buffered; reset asserted in bit 4.
    task automatic test_reset_mid_word;
        logic [4:0] exp;
        pin       = 8'hFF;
        pin_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) pin_valid = 1'b0;
            exp = {1'b1, 1'b0, 1'b1, 1'b1, (c == 1)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs, exp);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid_immediate: vld/last/sout/busy/rdy got %b want %b", obs, 5'b00000);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid_held: vld/last/sout/busy/rdy got %b want %b", obs, 5'b00000);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_mid_release: vld/last/sout/busy/rdy got %b want %b", obs, 5'b00001);
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 5'b00001) begin
                n_fail++;
                $display("FAIL reset_mid_residual cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs, 5'b00001);
            end
        end
    endtask

    // WIDTH=4, LSB-first, 0x6 -> 0,1,1,0.
    task automatic test_lsb_first;
        logic [3:0] stream = 4'b0110;
        logic [4:0] exp;
        pin4       = 4'h6;
        pin4_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                pin4_valid = 1'b0;
                pin4       = 4'hF;
            end
            if (c <= 4) exp = {1'b1, (c == 4), stream[4-c], 1'b1, 1'b1};
            else        exp = 5'b00001;
            n_checks++;
            if (obs4 !== exp) begin
                n_fail++;
                $display("FAIL lsb_first cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs4, exp);
            end
        end
    endtask

    // 0x3C presented only in the sout_last cycle of 0xA5 with the hold slot empty.
    task automatic test_same_cycle_reload;
        logic [15:0] stream = 16'b1010_0101_0011_1100;
        logic [4:0]  exp;
        pin       = 8'hA5;
        pin_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) pin_valid = 1'b0;
            if (c == 8) begin
                pin       = 8'h3C;
                pin_valid = 1'b1;
            end
            if (c == 9) pin_valid = 1'b0;
            if (c <= 16) exp = {1'b1, (c == 8 || c == 16), stream[16-c], 1'b1, 1'b1};
            else         exp = 5'b00001;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL same_cycle_reload cycle %0d: vld/last/sout/busy/rdy got %b want %b", c, obs, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_lsb_first();
        test_same_cycle_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psconverter.md
PSCONVERTER -- requirements
Module: psconverter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits; legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB transmitted first and 0 = LSB transmitted first.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port pin, input, WIDTH, parallel data word from the producer.
REQ-006 SHALL have port pin_valid, input, 1, pin holds a word to transfer.
REQ-007 SHALL have port pin_ready, output, 1, block can accept a word this cycle.
REQ-008 SHALL have port sout, output, 1, serial data bit to the downstream serial-to-parallel stage.
REQ-009 SHALL have port sout_valid, output, 1, sout carries a valid bit this cycle.
REQ-010 SHALL have port sout_last, output, 1, sout carries the final bit of a word.
REQ-011 SHALL have port busy, output, 1, a word is being shifted or a word is buffered.

Function
REQ-012 SHALL contain these registers: a WIDTH-bit shift register, a WIDTH-bit holding register with flag hold_full, and a bit counter of clog2(WIDTH) bits.
REQ-013 SHALL implement a 2-state FSM with states IDLE and SHIFT.
REQ-014 SHALL drive pin_ready = rst AND NOT hold_full; a transfer occurs on a rising edge where pin_valid and pin_ready are both 1.
REQ-015 SHALL, in IDLE on a transfer, load pin into the shift register, clear the counter and enter SHIFT; hold_full is not set.
REQ-016 SHALL set latency to 1 cycle: the first bit of a word accepted at edge N is on sout with sout_valid=1 in the cycle after edge N.
REQ-017 SHALL, in SHIFT on a transfer, store pin in the holding register and set hold_full.
REQ-018 SHALL drive sout_valid=1 exactly when the state is SHIFT.
REQ-019 SHALL drive sout from the shift register bit WIDTH-1 when MSB_FIRST=1, or from bit 0 when MSB_FIRST=0.
REQ-020 SHALL, in SHIFT at each edge with counter < WIDTH-1, shift the register one position toward the output end, zero-fill the vacated bit and increment the counter.
REQ-021 SHALL drive sout_last=1 when the state is SHIFT and the counter equals WIDTH-1.
REQ-022 SHALL apply the following priority at the last-bit edge:
  - (a) hold_full=1: load the shift register from the holding register, clear hold_full and the counter, stay in SHIFT.
  - (b) otherwise, on a same-cycle transfer: load pin directly, clear the counter, stay in SHIFT.
  - (c) otherwise: enter IDLE.
REQ-023 SHALL, under REQ-022 (a) and (b), produce back-to-back words with no idle cycle between the last bit of one word and the first bit of the next.
REQ-024 SHALL never accept a word while hold_full=1, since pin_ready=0; at most 2 words are in flight.
REQ-025 SHALL drive busy = (state==SHIFT) OR hold_full.
REQ-026 SHALL leave pin values that arrive without a transfer with no effect on state.

Reset
REQ-027 SHALL, while rst=0, immediately force:
  - state=IDLE
  - shift register, holding register and counter = 0
  - hold_full=0
  - sout=0, sout_valid=0, sout_last=0, busy=0, pin_ready=0
REQ-028 SHALL, after rst rises, have pin_ready=1 in the first cycle and all other outputs 0.
REQ-029 SHALL, on reset asserted mid-word, discard the partial word and the buffered word; no further bits of either are emitted after release.

Verification
REQ-030 SHALL cover single word: WIDTH=8, MSB_FIRST=1, pin=0xA5 accepted at edge 0 -> sout=1,0,1,0,0,1,0,1 in cycles 1..8, sout_valid=1 in cycles 1..8, sout_last=1 only in cycle 8, then IDLE with busy=0 in cycle 9.
REQ-031 SHALL cover back-to-back: 0xA5 then 0x3C, second accepted at edge 1 -> 16 contiguous valid bits, sout_last in cycles 8 and 16, pin_ready=0 in cycles 2..8.
REQ-032 SHALL cover backpressure: pin_valid held high with three words -> third accepted only after the holding register drains at the edge ending cycle 8; no word is lost or duplicated.
REQ-033 SHALL cover reset mid-word: rst=0 during bit 4 of 0xFF -> sout, sout_valid and busy are 0 in the same cycle; after release pin_ready=1 and no residual bits are emitted.
REQ-034 SHALL cover LSB-first: MSB_FIRST=0, WIDTH=4, pin=0x6 -> sout=0,1,1,0.
REQ-035 SHALL cover same-cycle reload: a new word presented exactly in the sout_last cycle with hold empty -> accepted there and its first bit follows in the next cycle.
